// File: rtl/conv_linebuf_ctrl_if.sv
// ============================================================================
// Module      : conv_linebuf_ctrl_if
// Description : Pixel-in, line-RAM and tap-pair-out bundle for the line-buffer
//               sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface conv_linebuf_ctrl_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
);
    logic                  sof_i;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  ram_wr_en;
    logic [ADDR_WIDTH-1:0] ram_wr_addr;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic                  ram_rd_clk_en;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_cur;
    logic [DATA_WIDTH-1:0] out_prev;
    logic [ADDR_WIDTH-1:0] out_col;
    logic [15:0]           out_row;
    logic                  frame_done;
    logic                  busy;

    // master: the sequencer itself; slave: pixel source, RAM and downstream.
    modport master (
        input  sof_i, in_valid, in_data, ram_rd_data,
        output ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr, ram_rd_clk_en,
        output out_valid, out_cur, out_prev, out_col, out_row, frame_done, busy
    );

    modport slave (
        output sof_i, in_valid, in_data, ram_rd_data,
        input  ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr, ram_rd_clk_en,
        input  out_valid, out_cur, out_prev, out_col, out_row, frame_done, busy
    );
endinterface

`default_nettype wire

// File: rtl/conv_linebuf_ctrl.sv
// ============================================================================
// Module      : conv_linebuf_ctrl
// Description : One-line delay sequencer; pairs each pixel with the same
//               column of the previous row using an external SDP block RAM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module conv_linebuf_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int LINE_W     = 320,
    parameter int IMG_H      = 240
) (
    input  wire logic         clk,
    input  wire logic         rst,
    conv_linebuf_ctrl_if.master bus
);

    localparam logic [0:0]            c_st_idle   = 1'b0;
    localparam logic [0:0]            c_st_active = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] c_col_last  = ADDR_WIDTH'(LINE_W - 1);
    localparam logic [15:0]           c_row_last  = 16'(IMG_H - 1);

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_col;
    logic [15:0]           r_row;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_pix;
    logic [ADDR_WIDTH-1:0] r_s1_col;
    logic [15:0]           r_s1_row;
    logic                  r_s1_row0;
    logic                  r_s1_last;
    logic                  r_frame_done;

    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_pos_col;
    logic [15:0]           w_pos_row;
    logic                  w_col_wrap;
    logic                  w_last;

    // sof_i restarts at (0,0) and may carry the first pixel of the new frame.
    always_comb begin
        w_pos_col  = bus.sof_i ? '0 : r_col;
        w_pos_row  = bus.sof_i ? '0 : r_row;
        w_accept   = bus.in_valid && (bus.sof_i || (r_state == c_st_active));
        w_col_wrap = (w_pos_col == c_col_last);
        w_last     = w_accept && w_col_wrap && (w_pos_row == c_row_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_col        <= '0;
            r_row        <= '0;
            r_rd_addr    <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_pix     <= '0;
            r_s1_col     <= '0;
            r_s1_row     <= '0;
            r_s1_row0    <= 1'b1;
            r_s1_last    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_s1_valid   <= w_accept;
            r_s1_last    <= w_last;
            r_frame_done <= r_s1_valid && r_s1_last;

            if (w_accept) begin
                r_rd_addr <= w_pos_col;
                r_s1_pix  <= bus.in_data;
                r_s1_col  <= w_pos_col;
                r_s1_row  <= w_pos_row;
                r_s1_row0 <= (w_pos_row == 16'd0);
            end

            if (bus.sof_i) begin
                r_state <= c_st_active;
            end else if (w_last) begin
                r_state <= c_st_idle;
            end

            if (w_last) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_accept) begin
                if (w_col_wrap) begin
                    r_col <= '0;
                    r_row <= w_pos_row + 16'd1;
                end else begin
                    r_col <= w_pos_col + 1'b1;
                    r_row <= w_pos_row;
                end
            end else if (bus.sof_i) begin
                r_col <= '0;
                r_row <= '0;
            end
        end
    end

    // Read is issued in the accept cycle so RAM data lines up with stage S1.
    assign bus.ram_rd_clk_en = w_accept;
    assign bus.ram_rd_addr   = w_accept ? w_pos_col : r_rd_addr;

    assign bus.ram_wr_en     = r_s1_valid;
    assign bus.ram_wr_addr   = r_s1_col;
    assign bus.ram_wr_data   = r_s1_pix;

    assign bus.out_valid     = r_s1_valid;
    assign bus.out_cur       = r_s1_pix;
    assign bus.out_prev      = r_s1_row0 ? '0 : bus.ram_rd_data;
    assign bus.out_col       = r_s1_col;
    assign bus.out_row       = r_s1_row;
    assign bus.frame_done    = r_frame_done;
    assign bus.busy          = (r_state == c_st_active);

endmodule

`default_nettype wire
